// File: rtl/pipeline_trap_controller.sv
// pipeline_trap_controller: per-stage stall/flush generation plus prioritised trap sequencing toward the CSR unit
module pipeline_trap_controller #(
    parameter int NUM_STAGES   = 5,
    parameter int NUM_EXC      = 5,
    parameter int NUM_IRQ      = 3,
    parameter int CAUSE_W      = 5,
    parameter int BRANCH_STAGE = 2,
    parameter logic [NUM_EXC*CAUSE_W-1:0] EXC_CODES = {5'd11, 5'd6, 5'd4, 5'd2, 5'd0},
    parameter logic [NUM_IRQ*CAUSE_W-1:0] IRQ_CODES = {5'd7, 5'd3, 5'd11}
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_STAGES-1:0] stall_req_i,
    input  logic                  flush_branch_i,
    input  logic [NUM_EXC-1:0]    exc_valid_i,
    input  logic [NUM_IRQ-1:0]    irq_pending_i,
    input  logic                  irq_enable_i,
    input  logic                  mem_busy_i,
    input  logic                  trap_ack_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  trap_valid_o,
    output logic                  trap_is_irq_o,
    output logic [CAUSE_W-1:0]    trap_cause_o,
    output logic                  busy_o
);
    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;
    state_t state;
    logic exc_any, irq_take;
    logic [CAUSE_W-1:0] exc_cause, irq_cause;
    logic [NUM_STAGES-1:0] back;
    assign exc_any  = |exc_valid_i;
    assign irq_take = irq_enable_i && (|irq_pending_i);
    assign busy_o   = state != IDLE;
    always_comb begin
        exc_cause = '0;
        irq_cause = '0;
        for (int k = NUM_EXC - 1; k >= 0; k--)
            if (exc_valid_i[k]) exc_cause = EXC_CODES[k*CAUSE_W +: CAUSE_W];
        for (int k = NUM_IRQ - 1; k >= 0; k--)
            if (irq_pending_i[k]) irq_cause = IRQ_CODES[k*CAUSE_W +: CAUSE_W];
    end
    always_comb begin
        back = '0;
        back[NUM_STAGES-1] = stall_req_i[NUM_STAGES-1];
        for (int k = NUM_STAGES - 2; k >= 0; k--) back[k] = stall_req_i[k] | back[k+1];
    end
    always_comb begin
        stall_o = '0;
        flush_o = '0;
        if (state == DRAIN || (state == IDLE && (exc_any || irq_take))) stall_o = '1;
        else if (state == FLUSH) flush_o = '1;
        else begin
            stall_o = back;
            if (flush_branch_i)
                for (int k = 0; k < BRANCH_STAGE; k++) begin
                    stall_o[k] = 1'b0;
                    flush_o[k] = 1'b1;
                end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            trap_valid_o  <= 1'b0;
            trap_is_irq_o <= 1'b0;
            trap_cause_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (exc_any) begin
                        trap_cause_o  <= exc_cause;
                        trap_is_irq_o <= 1'b0;
                        trap_valid_o  <= 1'b1;
                        state         <= FLUSH;
                    end else if (irq_take) begin
                        trap_cause_o  <= irq_cause;
                        trap_is_irq_o <= 1'b1;
                        state         <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (exc_any) begin
                        trap_cause_o  <= exc_cause;
                        trap_is_irq_o <= 1'b0;
                    end
                    if (!mem_busy_i) begin
                        trap_valid_o <= 1'b1;
                        state        <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (trap_valid_o && trap_ack_i) begin
                        trap_valid_o <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/pipeline_trap_controller.md
Name: pipeline_trap_controller

Overview:
Parametrised pipeline hazard and trap controller for the in-order core. Generates per-stage stall and flush vectors from per-stage stall requests and branch misprediction. Prioritises N exception and M interrupt sources into an encoded cause. Sequences a drain/flush/handoff FSM with a valid/ack handshake to the CSR unit.

Parameters:
NUM_STAGES, 5, pipeline stage count; index 0 = fetch, NUM_STAGES-1 = writeback
NUM_EXC, 5, exception source count; index 0 = highest priority
NUM_IRQ, 3, interrupt source count; index 0 = highest priority
CAUSE_W, 5, cause code width
BRANCH_STAGE, 2, stage that resolves branches; stages below it are flushed on mispredict
EXC_CODES, {5'd11,5'd6,5'd4,5'd2,5'd0}, packed NUM_EXC*CAUSE_W cause codes; slice i = source i
IRQ_CODES, {5'd7,5'd3,5'd11}, packed NUM_IRQ*CAUSE_W cause codes

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
stall_req_i  in  NUM_STAGES  per-stage stall request
flush_branch_i  in  1  branch misprediction at BRANCH_STAGE
exc_valid_i  in  NUM_EXC  exceptions reported at the commit point
irq_pending_i  in  NUM_IRQ  pending and individually enabled interrupts
irq_enable_i  in  1  global interrupt enable (mstatus.MIE)
mem_busy_i  in  1  outstanding memory transaction
trap_ack_i  in  1  CSR unit accepted trap; redirect PC ready
stall_o  out  NUM_STAGES  per-stage stall
flush_o  out  NUM_STAGES  per-stage flush (insert bubble)
trap_valid_o  out  1  trap request to CSR unit
trap_is_irq_o  out  1  1 = interrupt, 0 = exception
trap_cause_o  out  CAUSE_W  encoded cause
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_i=1 at a clock edge): state IDLE; trap_valid_o, trap_is_irq_o, trap_cause_o are 0. Combinational outputs settle to their IDLE values. Reset in any state aborts the trap; trap_valid_o is 0 from the next cycle.
- trap_valid_o, trap_is_irq_o and trap_cause_o are registered. stall_o, flush_o and busy_o are combinational from state and inputs.
- IDLE, no trap event:
  - stall_o[i] = OR of stall_req_i[j] for all j >= i (backpressure propagates toward fetch).
  - flush_branch_i=1: flush_o[i]=1 and stall_o[i]=0 for i < BRANCH_STAGE (flush beats stall there). Stages >= BRANCH_STAGE are unaffected.
- Priority encode: lowest asserted index wins. Cause = corresponding CAUSE_W slice.
- IDLE transitions:
  - Any exc_valid_i set: capture exception cause, set is_irq=0, go FLUSH. stall_o is all ones and flush_branch_i is ignored that cycle.
  - Else irq_enable_i=1 and any irq_pending_i set: capture interrupt cause, set is_irq=1, go DRAIN. stall_o is all ones that cycle.
  - Exception beats interrupt in the same cycle.
- DRAIN: stall_o all ones, flush_o zero.
  - mem_busy_i=0: go FLUSH.
  - exc_valid_i set during DRAIN (e.g. fault on the drained access): overwrite cause with the exception, is_irq=0, still wait for mem_busy_i=0.
  - Interrupt deassertion during DRAIN does not cancel the trap; the captured cause is kept.
- FLUSH:
  - flush_o all ones and stall_o all zeros every cycle.
  - trap_valid_o=1, with cause and is_irq held stable until acknowledged.
  - trap_ack_i is honoured only while trap_valid_o=1. On ack, go IDLE; trap_valid_o=0 the next cycle.
  - New exc_valid_i and irq_pending_i are ignored in FLUSH.
- trap_ack_i while trap_valid_o=0 is ignored.
- flush_branch_i outside IDLE is ignored (superseded by the trap flush).
- busy_o = (state != IDLE).
- Back-to-back traps: IDLE is occupied for at least one cycle between traps. Events present in that IDLE cycle start a new trap.

Test Plan:
1. stall_req_i=5'b01000, no events -> stall_o=5'b01111, flush_o=0, busy_o=0.
2. flush_branch_i=1 with stall_req_i=5'b00001 -> flush_o=5'b00011, stall_o=5'b00000. Repeat with stall_req_i=5'b00100 -> flush_o=5'b00011, stall_o=5'b00100.
3. exc_valid_i=5'b10100 with irq_pending_i=3'b001 and irq_enable_i=1:
   - Same cycle: stall_o=5'b11111.
   - Next cycle: trap_valid_o=1, trap_cause_o=4, trap_is_irq_o=0, flush_o=5'b11111.
   - Hold trap_ack_i=0 for 3 cycles: outputs stable.
   - trap_ack_i=1: trap_valid_o=0 and busy_o=0 on the following cycle.
4. irq_pending_i=3'b110, irq_enable_i=1, mem_busy_i=1 for 4 cycles:
   - busy_o=1, stall_o all ones, trap_valid_o=0 for 4 cycles.
   - Then mem_busy_i=0: trap_valid_o=1, cause=3, is_irq=1.
   - With irq_enable_i=0 instead: no trap, busy_o=0.
5. In DRAIN, assert exc_valid_i=5'b01000, then drop mem_busy_i -> trap_cause_o=6, trap_is_irq_o=0.
6. rst_i=1 during FLUSH with trap_valid_o=1 -> next cycle trap_valid_o=0, trap_cause_o=0, busy_o=0, flush_o=0. trap_ack_i pulsed in IDLE has no effect.
